// File: rtl/crc_seq_arb.sv
// Two-channel word-serial CRC engine sharing one external 256-entry lookup table.
// A round-robin arbiter in IDLE picks a channel; RUN folds one byte per cycle into that channel's context.
module crc_seq_arb #(
    parameter logic [31:0] CRC_INIT = 32'h0,
    parameter logic [31:0] XOR_OUT  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_data_0,
    input  logic [31:0] req_data_1,
    input  logic        req_first_0,
    input  logic        req_first_1,
    input  logic        req_last_0,
    input  logic        req_last_1,
    output logic [31:0] crc_0,
    output logic [31:0] crc_1,
    output logic        crc_valid_0,
    output logic        crc_valid_1,
    output logic [31:0] tab_addr,
    input  logic [31:0] tab_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] data_q, data_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        chan_q, chan_d;
    logic        prio_q, prio_d;
    logic [31:0] ctx0_q, ctx0_d;
    logic [31:0] ctx1_q, ctx1_d;
    logic [31:0] crc0_q, crc0_d;
    logic [31:0] crc1_q, crc1_d;
    logic        crcv0_q, crcv0_d;
    logic        crcv1_q, crcv1_d;

    logic        grant;
    logic [7:0]  cur_byte;
    logic [31:0] base;
    logic [31:0] ctx_new;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        data_d      = data_q;
        first_d     = first_q;
        last_d      = last_q;
        chan_d      = chan_q;
        prio_d      = prio_q;
        ctx0_d      = ctx0_q;
        ctx1_d      = ctx1_q;
        crc0_d      = crc0_q;
        crc1_d      = crc1_q;
        crcv0_d     = 1'b0;
        crcv1_d     = 1'b0;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        tab_addr    = 32'h0;

        // prio_q names the channel that wins when both request.
        grant = req_valid_0 ? (req_valid_1 ? prio_q : 1'b0) : 1'b1;

        case (byte_cnt_q)
            2'd0:    cur_byte = data_q[31:24];
            2'd1:    cur_byte = data_q[23:16];
            2'd2:    cur_byte = data_q[15:8];
            default: cur_byte = data_q[7:0];
        endcase
        if (first_q && byte_cnt_q == 2'd0) base = CRC_INIT;
        else                               base = chan_q ? ctx1_q : ctx0_q;
        ctx_new = {base[23:0], 8'h00} ^ tab_rdata;

        case (state_q)
            IDLE: begin
                if (req_valid_0 || req_valid_1) begin
                    req_ready_0 = ~grant;
                    req_ready_1 = grant;
                    data_d      = grant ? req_data_1  : req_data_0;
                    first_d     = grant ? req_first_1 : req_first_0;
                    last_d      = grant ? req_last_1  : req_last_0;
                    chan_d      = grant;
                    prio_d      = ~grant;
                    byte_cnt_d  = 2'd0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                tab_addr   = {24'h0, base[31:24] ^ cur_byte};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (chan_q) ctx1_d = ctx_new;
                else        ctx0_d = ctx_new;
                if (byte_cnt_q == 2'd3) begin
                    if (last_q) begin
                        // Result and its pulse become visible together during DONE.
                        state_d = DONE;
                        if (chan_q) begin
                            crc1_d  = ctx_new ^ XOR_OUT;
                            crcv1_d = 1'b1;
                        end else begin
                            crc0_d  = ctx_new ^ XOR_OUT;
                            crcv0_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (chan_q) ctx1_d = CRC_INIT;
                else        ctx0_d = CRC_INIT;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            data_q     <= 32'h0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            chan_q     <= 1'b0;
            prio_q     <= 1'b0;
            ctx0_q     <= CRC_INIT;
            ctx1_q     <= CRC_INIT;
            crc0_q     <= 32'h0;
            crc1_q     <= 32'h0;
            crcv0_q    <= 1'b0;
            crcv1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            first_q    <= first_d;
            last_q     <= last_d;
            chan_q     <= chan_d;
            prio_q     <= prio_d;
            ctx0_q     <= ctx0_d;
            ctx1_q     <= ctx1_d;
            crc0_q     <= crc0_d;
            crc1_q     <= crc1_d;
            crcv0_q    <= crcv0_d;
            crcv1_q    <= crcv1_d;
        end
    end

    assign crc_0       = crc0_q;
    assign crc_1       = crc1_q;
    assign crc_valid_0 = crcv0_q;
    assign crc_valid_1 = crcv1_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_crc_seq_arb.sv
// Directed bench for crc_seq_arb: single-word vector table, arbitration, discard and reset sequences.
// The external table is an MSB-first table for polynomial 32'h07f6e306 with entry 8'hff pinned to 32'ha68e986c.
module tb_crc_seq_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_data_0 = 32'h0, req_data_1 = 32'h0;
    logic        req_first_0 = 1'b0, req_first_1 = 1'b0;
    logic        req_last_0 = 1'b0, req_last_1 = 1'b0;
    logic [31:0] crc_0, crc_1;
    logic        crc_valid_0, crc_valid_1;
    logic [31:0] tab_addr, tab_rdata;
    logic        busy;

    logic        x_valid_0 = 1'b0;
    logic        x_ready_0, x_ready_1;
    logic [31:0] x_data_0 = 32'h0;
    logic        x_first_0 = 1'b0, x_last_0 = 1'b0;
    logic [31:0] x_crc_0, x_crc_1;
    logic        x_crc_valid_0, x_crc_valid_1;
    logic [31:0] x_tab_addr, x_tab_rdata;
    logic        x_busy;

    logic [31:0] tab [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_crc [2];
    logic [0:0]  exp_q [$];
    logic [0:0]  grant_q [$];
    logic        mon_en = 1'b0;

    typedef struct {
        logic        ch;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    assign tab_rdata   = tab[tab_addr[7:0]];
    assign x_tab_rdata = tab[x_tab_addr[7:0]];

    crc_seq_arb u_dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_data_0(req_data_0), .req_data_1(req_data_1),
        .req_first_0(req_first_0), .req_first_1(req_first_1),
        .req_last_0(req_last_0), .req_last_1(req_last_1),
        .crc_0(crc_0), .crc_1(crc_1),
        .crc_valid_0(crc_valid_0), .crc_valid_1(crc_valid_1),
        .tab_addr(tab_addr), .tab_rdata(tab_rdata), .busy(busy)
    );

    crc_seq_arb #(.CRC_INIT(32'h0), .XOR_OUT(32'hffffffff)) u_dut_x (
        .clk(clk), .rst(rst),
        .req_valid_0(x_valid_0), .req_valid_1(1'b0),
        .req_ready_0(x_ready_0), .req_ready_1(x_ready_1),
        .req_data_0(x_data_0), .req_data_1(32'h0),
        .req_first_0(x_first_0), .req_first_1(1'b0),
        .req_last_0(x_last_0), .req_last_1(1'b0),
        .crc_0(x_crc_0), .crc_1(x_crc_1),
        .crc_valid_0(x_crc_valid_0), .crc_valid_1(x_crc_valid_1),
        .tab_addr(x_tab_addr), .tab_rdata(x_tab_rdata), .busy(x_busy)
    );

    always @(posedge clk) begin
        if (mon_en) begin
            if (req_valid_0 && req_ready_0) grant_q.push_back(1'b0);
            if (req_valid_1 && req_ready_1) grant_q.push_back(1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] c_in, input logic [31:0] d, input bit first);
        logic [31:0] c;
        logic [7:0]  b;
        c = first ? 32'h0 : c_in;
        for (int i = 0; i < 4; i++) begin
            b = 8'(d >> (24 - 8 * i));
            c = (c << 8) ^ tab[c[31:24] ^ b];
        end
        return c;
    endfunction

    task automatic send(input int ch, input logic [31:0] d, input logic f, input logic l);
        int   n;
        logic rdy;
        @(negedge clk);
        if (ch == 0) begin
            req_data_0 = d; req_first_0 = f; req_last_0 = l; req_valid_0 = 1'b1;
        end else begin
            req_data_1 = d; req_first_1 = f; req_last_1 = l; req_valid_1 = 1'b1;
        end
        #1;
        n = 0;
        rdy = (ch == 0) ? req_ready_0 : req_ready_1;
        while (!rdy && n < 60) begin
            @(negedge clk); #1;
            n++;
            rdy = (ch == 0) ? req_ready_0 : req_ready_1;
        end
        check($sformatf("accept_ch%0d", ch), {31'h0, rdy}, 32'h1);
        @(posedge clk); #1;
        if (ch == 0) req_valid_0 = 1'b0;
        else         req_valid_1 = 1'b0;
    endtask

    task automatic wait_crc(input int ch, output int cyc);
        logic v;
        cyc = 1;
        v = (ch == 0) ? crc_valid_0 : crc_valid_1;
        while (!v && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            v = (ch == 0) ? crc_valid_0 : crc_valid_1;
        end
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [31:0] m0, m1;
        logic [31:0] w0 [3];
        logic [31:0] w1 [3];

        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i) << 24;
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h07f6e306) : (c << 1);
            tab[i] = c;
        end
        tab[255] = 32'ha68e986c;

        vecs[0] = '{1'b0, 32'h00000001, 32'h07f6e306};
        vecs[1] = '{1'b1, 32'h000000ff, 32'ha68e986c};
        vecs[2] = '{1'b0, 32'h00000000, 32'h00000000};
        vecs[3] = '{1'b1, 32'h00000100, 32'he123af12};
        vecs[4] = '{1'b0, 32'h00000002, 32'h0fedc60c};
        exp_crc[0] = 32'h0;
        exp_crc[1] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_crc_0", crc_0, 32'h0);
        check("rst_crc_1", crc_1, 32'h0);
        check("rst_crc_valid", {30'h0, crc_valid_1, crc_valid_0}, 32'h0);
        check("rst_tab_addr", tab_addr, 32'h0);
        check("rst_ready_idle", {30'h0, req_ready_1, req_ready_0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            int ch;
            ch = int'(vecs[i].ch);
            send(ch, vecs[i].data, 1'b1, 1'b1);
            check($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h1);
            wait_crc(ch, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            exp_crc[ch] = vecs[i].exp;
            check($sformatf("vec%0d_crc", i), (ch == 0) ? crc_0 : crc_1, vecs[i].exp);
            check($sformatf("vec%0d_other_crc", i), (ch == 0) ? crc_1 : crc_0, exp_crc[1 - ch]);
            check($sformatf("vec%0d_other_valid", i), {31'h0, (ch == 0) ? crc_valid_1 : crc_valid_0}, 32'h0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse_end", i), {31'h0, (ch == 0) ? crc_valid_0 : crc_valid_1}, 32'h0);
            check($sformatf("vec%0d_idle", i), {31'h0, busy}, 32'h0);
        end

        // Both channels stream 3-word messages with valid held; grants must alternate.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w0[0] = 32'h11111111; w0[1] = 32'h22222222; w0[2] = 32'h33333333;
        w1[0] = 32'ha5a5a5a5; w1[1] = 32'h5a5a5a5a; w1[2] = 32'hdeadbeef;
        grant_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
        end
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) send(0, w0[i], i == 0, i == 2);
            end
            begin
                for (int i = 0; i < 3; i++) send(1, w1[i], i == 0, i == 2);
            end
        join
        repeat (8) @(posedge clk);
        #1;
        mon_en = 1'b0;
        m0 = 32'h0;
        m1 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            m0 = model_word(m0, w0[i], i == 0);
            m1 = model_word(m1, w1[i], i == 0);
        end
        check("rr_grant_count", 32'(grant_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_q.size()) check($sformatf("rr_grant%0d", i), {31'h0, grant_q[i]}, {31'h0, exp_q[i]});
        end
        check("rr_crc_0", crc_0, m0);
        check("rr_crc_1", crc_1, m1);
        exp_crc[0] = m0;
        exp_crc[1] = m1;

        // A non-last word leaves partial context that a following first word must discard.
        send(0, 32'h12345678, 1'b1, 1'b0);
        check("partial_tab_addr_b0", tab_addr, 32'h00000012);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (crc_valid_0) pulses++;
        end
        check("partial_no_pulse", 32'(pulses), 32'd0);
        check("partial_crc_hold", crc_0, exp_crc[0]);
        send(0, 32'h00000001, 1'b1, 1'b1);
        wait_crc(0, lat);
        check("discard_latency", 32'(lat), 32'd5);
        check("discard_crc_0", crc_0, 32'h07f6e306);
        check("discard_crc_1_hold", crc_1, exp_crc[1]);
        exp_crc[0] = 32'h07f6e306;
        repeat (2) @(posedge clk);

        // Reset lands while byte 2 of a word is being folded.
        send(0, 32'h00000001, 1'b1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_run_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_tab_addr", tab_addr, 32'h0);
        check("mid_rst_crc_0", crc_0, 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (crc_valid_0 || crc_valid_1) pulses++;
            if (i == 2) rst = 1'b0;
        end
        check("mid_rst_no_pulse", 32'(pulses), 32'd0);
        send(0, 32'h00000001, 1'b1, 1'b1);
        wait_crc(0, lat);
        check("post_rst_latency", 32'(lat), 32'd5);
        check("post_rst_crc_0", crc_0, 32'h07f6e306);

        // Inverted-output instance.
        check("x_rst_crc_0", x_crc_0, 32'h0);
        @(negedge clk);
        x_data_0 = 32'h0; x_first_0 = 1'b1; x_last_0 = 1'b1; x_valid_0 = 1'b1;
        #1;
        check("x_ready", {31'h0, x_ready_0}, 32'h1);
        @(posedge clk); #1;
        x_valid_0 = 1'b0;
        lat = 1;
        while (!x_crc_valid_0 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("x_latency", 32'(lat), 32'd5);
        check("x_crc_0", x_crc_0, 32'hffffffff);
        check("x_crc_1_untouched", x_crc_1, 32'h0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
